fighter_motion: RTL and testbench
=================================

FIGHTER_MOTION -- requirements
Module: fighter_motion

Interface
REQ-001 Parameters SHALL be: START_X, default 10'd100, reset X position; FLOOR_Y, default 10'd280, ground Y of sprite top-left; X_MIN, default 10'd0, left limit; X_MAX, default 10'd639, right screen limit; SPRITE_W, default 10'd120, sprite width; WALK_STEP, default 10'd3, pixels per frame; JUMP_V0, default 10'd18, initial upward speed; GRAVITY, default 10'd1, per-frame speed change; KEY_L, default 8'h04, left keycode; KEY_R, default 8'h07, right keycode; KEY_J, default 8'h1A, jump keycode.
REQ-002 Port Clk SHALL be an input, 1 bit wide, and the single system clock; all state SHALL change on its rising edge only.
REQ-003 Port Reset_n SHALL be an input, 1 bit wide, and a synchronous active-low reset.
REQ-004 Port frame_clk SHALL be an input, 1 bit wide, carrying VGA vsync, asynchronous to Clk.
REQ-005 Port keycode SHALL be an input, 8 bits wide, carrying the current key, with 8'h00 meaning none.
REQ-006 Port OtherX SHALL be an input, 10 bits wide, giving the opponent X position.
REQ-007 Port FighterX SHALL be an output, 10 bits wide, giving the sprite top-left X that feeds the color mapper X input.
REQ-008 Port FighterY SHALL be an output, 10 bits wide, giving the sprite top-left Y that feeds the color mapper Y input.
REQ-009 Port sprite SHALL be an output, 3 bits wide, giving the pose index for the sprite ROM: 0 idle, 1 walk, 2 jump.
REQ-010 Port frame_tick SHALL be an output, 1 bit wide, a one-Clk pulse per detected frame, for debug and downstream use.

Function
REQ-011 frame_clk SHALL pass through a 2-flop synchronizer; frame_tick SHALL assert for exactly one Clk on each synchronized rising edge, 3 Clk after the edge of frame_clk.
REQ-012 FSM states SHALL be IDLE, WALK_L, WALK_R, AIR; transitions and position updates SHALL be evaluated only in cycles where frame_tick=1; outputs SHALL hold otherwise.
REQ-013 From IDLE, WALK_L or WALK_R: keycode==KEY_J -> AIR with VelY=-JUMP_V0; else KEY_L -> WALK_L; else KEY_R -> WALK_R; else -> IDLE. KEY_J SHALL take priority.
REQ-014 In WALK_L, the candidate X SHALL be X-WALK_STEP, saturated at X_MIN with no 10-bit unsigned wrap-around; in WALK_R, the candidate X SHALL be X+WALK_STEP, saturated at X_MAX-SPRITE_W+1.
REQ-015 Anti-overlap: when moving toward the opponent, if the candidate box [cand, cand+SPRITE_W) intersects [OtherX, OtherX+SPRITE_W), X SHALL hold its current value; moving away SHALL never be blocked.
REQ-016 AIR: each tick, Y SHALL become Y+VelY as signed 11-bit arithmetic, and VelY SHALL become VelY+GRAVITY; horizontal input SHALL be ignored while in AIR.
REQ-017 Landing: if Y+VelY >= FLOOR_Y (signed compare), Y SHALL be set to FLOOR_Y, VelY SHALL be set to 0, and the state SHALL go to IDLE on the same tick; Y SHALL never exceed FLOOR_Y.
REQ-018 Y SHALL never go below 0; if Y+VelY < 0, Y SHALL be set to 0 and the ascent continues under gravity.
REQ-019 sprite SHALL be 0 in IDLE, 1 in WALK_L and WALK_R, and 2 in AIR, registered alongside X and Y so that all three update in the same Clk.
REQ-020 FighterX, FighterY and sprite SHALL be direct register outputs with no combinational path from any input.

Reset
REQ-021 When Reset_n=0 at a Clk edge, the next outputs SHALL be: FighterX=START_X, FighterY=FLOOR_Y, sprite=0, frame_tick=0, state=IDLE, VelY=0, and the synchronizer flops cleared.
REQ-022 Reset SHALL override any tick in the same cycle, including one asserted mid-jump; the first tick after release SHALL be processed from IDLE.
REQ-023 A frame_clk edge occurring during reset SHALL NOT produce a tick after release unless a new edge arrives.

Verification
REQ-024 Reset mid-jump with Reset_n=0 for one Clk SHALL give X=100, Y=280, sprite=0; ten subsequent ticks with keycode=0 SHALL leave all outputs unchanged.
REQ-025 Walk clamp: with X=2, keycode=8'h04 and one tick, X SHALL become 0 with no wrap-around; with X=518, keycode=8'h07 and one tick, X SHALL become 520.
REQ-026 Jump arc: with keycode=8'h1A for one tick then released, Y SHALL follow 262, 245, 229, ...; Y SHALL land exactly at 280 on the 37th tick with sprite=0; sprite SHALL be 2 throughout the arc.
REQ-027 Overlap: with X=100, OtherX=222 and keycode=8'h07, X SHALL hold at 100; with keycode=8'h04, X SHALL become 97.
REQ-028 Tick timing: a single frame_clk pulse SHALL produce exactly one frame_tick 3 Clk later; with frame_clk held high for 1000 Clk, only one update SHALL occur.
REQ-029 Priority: with keycode=8'h1A in WALK_R, the state SHALL enter AIR and X SHALL remain unchanged on that tick and during the flight.

Source files
------------

// File: rtl/fighter_motion.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fighter_motion : frame-paced fighter walk/jump FSM with sprite pose   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fighter_motion #(
  parameter logic [9:0] START_X   = 10'd100,
  parameter logic [9:0] FLOOR_Y   = 10'd280,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] SPRITE_W  = 10'd120,
  parameter logic [9:0] WALK_STEP = 10'd3,
  parameter logic [9:0] JUMP_V0   = 10'd18,
  parameter logic [9:0] GRAVITY   = 10'd1,
  parameter logic [7:0] KEY_L     = 8'h04,
  parameter logic [7:0] KEY_R     = 8'h07,
  parameter logic [7:0] KEY_J     = 8'h1A
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] OtherX,
  output logic [9:0] FighterX,
  output logic [9:0] FighterY,
  output logic [2:0] sprite,
  output logic       frame_tick
);

  typedef enum logic [1:0] {IDLE, WALK_L, WALK_R, AIR} state_t;

  localparam logic [10:0]        X_RLIM   = {1'b0, X_MAX} - {1'b0, SPRITE_W} + 11'd1;
  localparam logic signed [10:0] VEL_JUMP = -$signed({1'b0, JUMP_V0});
  localparam logic signed [10:0] VEL_GRAV = $signed({1'b0, GRAVITY});
  localparam logic signed [11:0] Y_FLOOR  = $signed({2'b00, FLOOR_Y});

  logic       fc_meta_q, fc_sync_q, fc_prev_q, tick_q;
  logic [2:0] vld_q;

  // vld_q blanks edge detection until fc_prev_q holds a real post-reset
  // sample, so a level already high across reset is not seen as an edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fc_meta_q <= 1'b0;
      fc_sync_q <= 1'b0;
      fc_prev_q <= 1'b0;
      vld_q     <= 3'b000;
      tick_q    <= 1'b0;
    end else begin
      fc_meta_q <= frame_clk;
      fc_sync_q <= fc_meta_q;
      fc_prev_q <= fc_sync_q;
      vld_q     <= {vld_q[1:0], 1'b1};
      tick_q    <= fc_sync_q & ~fc_prev_q & vld_q[2];
    end
  end

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [2:0]         sprite_q, sprite_d;
  logic signed [10:0] vel_q, vel_d;

  logic [10:0]        x_ext, rsum, other_hi;
  logic [9:0]         cand_l, cand_r;
  logic               block_l, block_r;
  logic signed [10:0] vel_sel;
  logic signed [11:0] y_sum;

  assign x_ext    = {1'b0, x_q};
  assign cand_l   = (x_ext < ({1'b0, X_MIN} + {1'b0, WALK_STEP})) ? X_MIN : (x_q - WALK_STEP);
  assign rsum     = x_ext + {1'b0, WALK_STEP};
  assign cand_r   = (rsum > X_RLIM) ? X_RLIM[9:0] : rsum[9:0];
  assign other_hi = {1'b0, OtherX} + {1'b0, SPRITE_W};

  // Only a step toward the opponent can be blocked by box intersection.
  assign block_l = (OtherX < x_q) && ({1'b0, cand_l} < other_hi)
                   && ({1'b0, OtherX} < ({1'b0, cand_l} + {1'b0, SPRITE_W}));
  assign block_r = (OtherX > x_q) && ({1'b0, cand_r} < other_hi)
                   && ({1'b0, OtherX} < ({1'b0, cand_r} + {1'b0, SPRITE_W}));

  assign vel_sel = (state_q == AIR) ? vel_q : VEL_JUMP;
  assign y_sum   = $signed({vel_sel[10], vel_sel}) + $signed({2'b00, y_q});

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vel_d    = vel_q;
    sprite_d = sprite_q;
    if (tick_q) begin
      if (state_q == AIR || keycode == KEY_J) begin
        state_d = AIR;
        if (y_sum >= Y_FLOOR) begin
          y_d     = FLOOR_Y;
          vel_d   = 11'sd0;
          state_d = IDLE;
        end else begin
          y_d   = y_sum[11] ? 10'd0 : y_sum[9:0];
          vel_d = vel_sel + VEL_GRAV;
        end
      end else if (keycode == KEY_L) begin
        state_d = WALK_L;
        if (!block_l) x_d = cand_l;
      end else if (keycode == KEY_R) begin
        state_d = WALK_R;
        if (!block_r) x_d = cand_r;
      end else begin
        state_d = IDLE;
      end
      case (state_d)
        IDLE:    sprite_d = 3'd0;
        AIR:     sprite_d = 3'd2;
        default: sprite_d = 3'd1;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      x_q      <= START_X;
      y_q      <= FLOOR_Y;
      vel_q    <= 11'sd0;
      sprite_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vel_q    <= vel_d;
      sprite_q <= sprite_d;
    end
  end

  assign FighterX   = x_q;
  assign FighterY   = y_q;
  assign sprite     = sprite_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_fighter_motion.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fighter_motion : directed scoreboard bench for fighter_motion      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fighter_motion;

  localparam logic [9:0] START_X = 10'd2;
  localparam logic [7:0] KL = 8'h04, KR = 8'h07, KJ = 8'h1A;

  logic       Clk, Reset_n, frame_clk, frame_tick;
  logic [7:0] keycode;
  logic [9:0] OtherX, FighterX, FighterY;
  logic [2:0] sprite;

  fighter_motion #(.START_X(START_X)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .OtherX(OtherX), .FighterX(FighterX), .FighterY(FighterY),
    .sprite(sprite), .frame_tick(frame_tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed { logic [9:0] x; logic [9:0] y; logic [2:0] sp; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int mx, my, mvel, mst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = START_X; my = 280; mvel = 0; mst = 0;
  endtask

  // Reference behaviour for one frame tick; st: 0 idle, 1 walk-left, 2 walk-right, 3 air.
  task automatic model_tick();
    int ny, v, c, ox;
    exp_t e;
    ox = int'(OtherX);
    if (mst == 3 || keycode == KJ) begin
      v = (mst == 3) ? mvel : -18;
      mst = 3;
      ny = my + v;
      if (ny >= 280) begin my = 280; mvel = 0; mst = 0; end
      else begin my = (ny < 0) ? 0 : ny; mvel = v + 1; end
    end else if (keycode == KL) begin
      mst = 1;
      c = mx - 3; if (c < 0) c = 0;
      if (!(ox < mx && c < ox + 120 && ox < c + 120)) mx = c;
    end else if (keycode == KR) begin
      mst = 2;
      c = mx + 3; if (c > 520) c = 520;
      if (!(ox > mx && c < ox + 120 && ox < c + 120)) mx = c;
    end else begin
      mst = 0;
    end
    e.x = mx[9:0]; e.y = my[9:0];
    e.sp = (mst == 3) ? 3'd2 : (mst == 0) ? 3'd0 : 3'd1;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_x"}, FighterX, e.x);
    chk({tag, "_y"}, FighterY, e.y);
    chk({tag, "_sprite"}, sprite, e.sp);
  endtask

  task automatic tick();
    int n;
    n = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    while (frame_tick !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("tick_latency", n, 3);
    model_tick();
    frame_clk = 1'b0;
    @(negedge Clk);
    chk("tick_width", frame_tick, 0);
    compare_out("step");
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    int n, cnt;
    Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00; OtherX = 10'd900;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge Clk);
    chk("rst_x", FighterX, START_X);
    chk("rst_y", FighterY, 280);
    chk("rst_sprite", sprite, 0);
    chk("rst_tick", frame_tick, 0);

    // Right walk up to the clamp at X_MAX-SPRITE_W+1.
    keycode = KR;
    repeat (172) tick();
    chk("walk_r_518", FighterX, 518);
    tick();
    chk("clamp_r_520", FighterX, 520);
    tick();
    chk("clamp_r_hold", FighterX, 520);

    keycode = KL;
    repeat (140) tick();
    chk("walk_l_100", FighterX, 100);

    // Opponent box adjacent on the right.
    OtherX = 10'd222;
    keycode = KR; tick();
    chk("ovl_block", FighterX, 100);
    keycode = KL; tick();
    chk("ovl_away", FighterX, 97);
    keycode = KR; tick();
    chk("back_100", FighterX, 100);

    // Jump from WALK_R; right key held in the air is ignored.
    keycode = KJ; tick();
    chk("jump_y1", FighterY, 262);
    chk("jump_sp", sprite, 2);
    chk("jump_x", FighterX, 100);
    keycode = KR;
    tick(); chk("jump_y2", FighterY, 245);
    tick(); chk("jump_y3", FighterY, 229);
    repeat (33) tick();
    chk("pre_land_y", FighterY, 262);
    chk("pre_land_sp", sprite, 2);
    tick();
    chk("land_y", FighterY, 280);
    chk("land_sp", sprite, 0);
    chk("land_x", FighterX, 100);

    // Reset mid-jump, coinciding with a tick, frame_clk held high through release.
    keycode = KJ; tick();
    keycode = 8'h00;
    repeat (4) tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (frame_tick !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("rst_tick_seen", n, 3);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    chk("midjump_rst_x", FighterX, START_X);
    chk("midjump_rst_y", FighterY, 280);
    chk("midjump_rst_sp", sprite, 0);
    cnt = 0;
    repeat (30) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) cnt++;
    end
    chk("no_tick_after_rst", cnt, 0);
    chk("post_rst_y", FighterY, 280);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    repeat (10) tick();
    chk("idle10_x", FighterX, START_X);
    chk("idle10_y", FighterY, 280);

    // Left clamp at X_MIN without wrap-around.
    keycode = KL; tick();
    chk("clamp_l_0", FighterX, 0);
    tick();
    chk("clamp_l_hold", FighterX, 0);

    // frame_clk held high for 1000 cycles yields a single update.
    keycode = KR;
    @(negedge Clk);
    frame_clk = 1'b1;
    cnt = 0;
    repeat (1000) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) cnt++;
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    chk("long_high_ticks", cnt, 1);
    model_tick();
    compare_out("long_high");
    chk("long_high_x", FighterX, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
